twpm_ram_arbiter: RTL and testbench
===================================

# twpm_ram_arbiter

Two-requester arbiter and sequencer for the 512x32 byte-writable single-port TPM buffer RAM. It shares the RAM between the host-interface side (port 0) and the MCU side (port 1) using round-robin arbitration and a req/ack handshake. It drives the RAM's address, write data, byte write enables and clock enables, and returns read data from the RAM's one-cycle registered output. It sits between the two bus front-ends and the RAM instance in the FPGA toplevel.

## Interface
Parameters:
- ADDR_W, 9, RAM word address width (512 words).
- DATA_W, 32, data width; byte lanes = DATA_W/8.

Ports:
- clk_i  in  1  single clock for the block and the RAM (RAM WClk/RClk tied to it).
- rst_ni  in  1  reset, asynchronous assert, active-low.
- req0_i, req1_i  in  1  access request per port; held high until the matching ack.
- we0_i, we1_i  in  1  1 = write, 0 = read.
- addr0_i, addr1_i  in  ADDR_W  word address.
- wdata0_i, wdata1_i  in  DATA_W  write data.
- be0_i, be1_i  in  DATA_W/8  byte enables for writes; ignored on reads.
- ack0_o, ack1_o  out  1  one-cycle completion pulse.
- rdata0_o, rdata1_o  out  DATA_W  read data; valid only while the matching ack is high and the access was a read, 0 otherwise.
- ram_a_o  out  ADDR_W  RAM address.
- ram_wd_o  out  DATA_W  RAM write data.
- ram_wen_o  out  DATA_W/8  RAM byte write enables.
- ram_wclk_en_o  out  1  RAM write enable.
- ram_rclk_en_o  out  1  RAM read enable.
- ram_rd_i  in  DATA_W  RAM read data; registered inside the RAM and updated on the clk_i edge that ends a cycle with ram_rclk_en_o=1.

## Operation
- The FSM has three states: IDLE, ISSUE and DONE. All state and all outputs are registered, except that rdata*_o is a gated pass-through of ram_rd_i.
- IDLE: if any req is high, the arbiter selects a winner and latches the winner's we, addr, wdata and be into command registers, then moves to ISSUE. If no req is high, it stays in IDLE.
- Arbitration:
  - If only one req is high, that port wins.
  - If both are high, the port not granted last wins. last_q records the most recently granted port and resets to 1, so port 0 wins the first tie.
- ISSUE (one cycle): ram_a_o and ram_wd_o come from the command registers.
  - Write: ram_wclk_en_o=1, ram_wen_o=be, ram_rclk_en_o=0.
  - Read: ram_rclk_en_o=1, ram_wclk_en_o=0, ram_wen_o=0.
  - Next state is DONE.
- DONE (one cycle): ack of the granted port = 1.
  - On a read, that port's rdata = ram_rd_i.
  - All RAM enables are 0, so RAM RD holds its value.
  - Next state is always IDLE. Requests are not sampled in DONE, because the served requester may still hold req high in this cycle.
- Outside ISSUE: ram_wclk_en_o = ram_rclk_en_o = 0 and ram_wen_o = 0. ram_a_o and ram_wd_o hold the command register values.
- A write with be=0 still completes the full sequence and acks; RAM contents are unchanged.
- A requester must drop req, or present a new request, in the cycle after it sees ack. A req still high in IDLE is treated as a new access.
- Command fields are latched at grant. Changes on the inputs after grant do not affect the current access.

## Timing
- Reset values: state IDLE, last_q=1, ack*_o=0, rdata*_o=0, ram_a_o=0, ram_wd_o=0, ram_wen_o=0, ram_wclk_en_o=0, ram_rclk_en_o=0, all command registers 0.
- Latency: req first seen high in IDLE at cycle N -> ISSUE at N+1 -> ack and rdata at N+2.
- Throughput: one access per 3 cycles. Under contention the two ports alternate strictly.
- A request arriving during ISSUE or DONE is served from the next IDLE.
- Reset asserted mid-access: all state and outputs go to reset values immediately. The pending access is dropped with no ack. If reset hits during ISSUE, the RAM write may or may not have occurred.
- The RAM read result is valid in DONE only; the block never reads ram_rd_i in any other state.

## Test plan
- Single write, then read: port0 writes 0xDEADBEEF to addr 0x005 with be=0xF, then reads addr 0x005.
  -> Write ack 2 cycles after grant, with ram_wclk_en_o high for exactly one cycle.
  -> Read ack carries rdata0_o=0xDEADBEEF; rdata1_o stays 0.
- Byte-lane write: 0x11223344 is stored at addr 0x1FF; port1 writes 0xAABBCCDD with be=0x5, then reads addr 0x1FF.
  -> rdata1_o = 0x11BB33DD.
- Simultaneous requests: req0 and req1 rise in the same cycle right after reset.
  -> ack0 at cycle N+2, ack1 at N+5.
  -> A second simultaneous pair is granted port1 first only if port0 was granted last (alternation holds).
- Continuous contention: both ports request back-to-back for 20 accesses.
  -> Grants alternate 0,1,0,1...; each port gets exactly 10 acks; every ack is a single-cycle pulse.
- Write with be=0: addr 0x010 holds 0xCAFEF00D; port0 writes 0xFFFFFFFF with be=0, then reads addr 0x010.
  -> The write acks normally; the read returns 0xCAFEF00D.
- Reset in ISSUE: rst_ni driven low during the ISSUE cycle of a port1 read.
  -> All outputs go to 0 asynchronously and no ack1 appears.
  -> After release, the same request completes normally in 3 cycles.

Source files
------------

// File: rtl/twpm_ram_arbiter_if.sv
// Requester-side bus of the TPM buffer RAM arbiter: two req/ack ports.
// Signal names carry their direction as seen from the arbiter.
interface twpm_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [BE_W-1:0]   be0_i;
  logic              ack0_o;
  logic [DATA_W-1:0] rdata0_o;

  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [BE_W-1:0]   be1_i;
  logic              ack1_o;
  logic [DATA_W-1:0] rdata1_o;

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i, be0_i,
    output req1_i, we1_i, addr1_i, wdata1_i, be1_i,
    input  ack0_o, rdata0_o, ack1_o, rdata1_o
  );

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i, be0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i, be1_i,
    output ack0_o, rdata0_o, ack1_o, rdata1_o
  );
endinterface

// File: rtl/twpm_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing the 512x32 single-port TPM buffer RAM
// between the host-interface port (0) and the MCU port (1); IDLE->ISSUE->DONE.
module twpm_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  twpm_ram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0]     ram_a_o,
  output logic [DATA_W-1:0]     ram_wd_o,
  output logic [DATA_W/8-1:0]   ram_wen_o,
  output logic                  ram_wclk_en_o,
  output logic                  ram_rclk_en_o,
  input  logic [DATA_W-1:0]     ram_rd_i
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [BE_W-1:0]   cmd_be_q, cmd_be_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              wclk_en_q, wclk_en_d;
  logic              rclk_en_q, rclk_en_d;
  logic [BE_W-1:0]   wen_q, wen_d;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      wclk_en_q   <= 1'b0;
      rclk_en_q   <= 1'b0;
      wen_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      wclk_en_q   <= wclk_en_d;
      rclk_en_q   <= rclk_en_d;
      wen_q       <= wen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    wclk_en_d   = 1'b0;
    rclk_en_d   = 1'b0;
    wen_d       = '0;

    // On a tie the port not granted last wins; a lone request always wins.
    win = (bus.req0_i && bus.req1_i) ? ~last_q : ~bus.req0_i;

    sel_we    = win ? bus.we1_i    : bus.we0_i;
    sel_addr  = win ? bus.addr1_i  : bus.addr0_i;
    sel_wdata = win ? bus.wdata1_i : bus.wdata0_i;
    sel_be    = win ? bus.be1_i    : bus.be0_i;

    case (state_q)
      IDLE: begin
        if (bus.req0_i || bus.req1_i) begin
          state_d     = ISSUE;
          last_d      = win;
          cmd_we_d    = sel_we;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          cmd_be_d    = sel_be;
          // RAM strobes are registered, so they are set up on the way into ISSUE.
          wclk_en_d   = sel_we;
          rclk_en_d   = ~sel_we;
          wen_d       = sel_we ? sel_be : '0;
        end
      end
      ISSUE: begin
        state_d = DONE;
        ack0_d  = ~last_q;
        ack1_d  = last_q;
      end
      DONE: begin
        // The served requester may still hold req here, so nothing is sampled.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_a_o       = cmd_addr_q;
  assign ram_wd_o      = cmd_wdata_q;
  assign ram_wen_o     = wen_q;
  assign ram_wclk_en_o = wclk_en_q;
  assign ram_rclk_en_o = rclk_en_q;

  assign bus.ack0_o   = ack0_q;
  assign bus.ack1_o   = ack1_q;
  // RAM RD is only meaningful in DONE, which is exactly when an ack is high.
  assign bus.rdata0_o = (ack0_q && !cmd_we_q) ? ram_rd_i : '0;
  assign bus.rdata1_o = (ack1_q && !cmd_we_q) ? ram_rd_i : '0;

endmodule

// File: tb/tb_twpm_ram_arbiter.sv
// Bench for twpm_ram_arbiter: directed and random traffic from two requesters,
// a behavioural RAM, and a transaction-level reference model of grants and data.
module tb_twpm_ram_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  twpm_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_wd;
  logic [BE_W-1:0]   ram_wen;
  logic              ram_wclk_en;
  logic              ram_rclk_en;
  logic [DATA_W-1:0] ram_rd = '0;

  twpm_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .ram_a_o       (ram_a),
    .ram_wd_o      (ram_wd),
    .ram_wen_o     (ram_wen),
    .ram_wclk_en_o (ram_wclk_en),
    .ram_rclk_en_o (ram_rclk_en),
    .ram_rd_i      (ram_rd)
  );

  // Behavioural byte-writable RAM with registered read port.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_wclk_en)
        for (int b = 0; b < BE_W; b++)
          if (ram_wen[b]) ram_mem[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
      if (ram_rclk_en) ram_rd <= ram_mem[ram_a];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t cur [2];
  bit   active [2];
  int   cyc, iss_cyc, done_cyc, free_cyc;
  bit   m_last;
  bit   g_port;
  cmd_t g_cmd;
  logic [DATA_W-1:0] g_rd;

  // Observation bookkeeping.
  logic [DATA_W-1:0] last_rd [2];
  int n_ack [2];
  int first_ack_cyc [2];
  int first_port;
  int prev_ack;
  bit alt_en;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic cmd_t pop(input int p);
    if (p == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic push(input int p, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.be = be;
    if (p == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(1));
    case ($urandom_range(3))
      0:       c.addr = ADDR_W'($urandom_range(15));
      1:       c.addr = '1;
      default: c.addr = ADDR_W'($urandom);
    endcase
    c.wdata = $urandom;
    c.be    = BE_W'($urandom);
    return c;
  endfunction

  task automatic drive(input bit iss);
    cmd_t c0, c1;
    c0 = cur[0];
    c1 = cur[1];
    // Once granted, the requester's fields are scrambled: only latched values may matter.
    if (iss && !g_port) c0 = rand_cmd();
    if (iss &&  g_port) c1 = rand_cmd();
    bus.req0_i = active[0]; bus.we0_i = c0.we; bus.addr0_i = c0.addr;
    bus.wdata0_i = c0.wdata; bus.be0_i = c0.be;
    bus.req1_i = active[1]; bus.we1_i = c1.we; bus.addr1_i = c1.addr;
    bus.wdata1_i = c1.wdata; bus.be1_i = c1.be;
  endtask

  task automatic note_ack(input int p);
    n_ack[p]++;
    if (first_ack_cyc[p] < 0) first_ack_cyc[p] = cyc;
    if (first_port < 0) first_port = p;
    if (alt_en && prev_ack >= 0) chk($sformatf("alternate_ack%0d", p), prev_ack, 1 - p);
    prev_ack = p;
  endtask

  // One cycle: check DUT outputs, advance requesters, let the model grant.
  task automatic step(input int pct);
    bit e_ack0, e_ack1, iss, w;
    e_ack0 = (cyc == done_cyc) && !g_port;
    e_ack1 = (cyc == done_cyc) &&  g_port;
    iss    = (cyc == iss_cyc);

    chk("ack0", bus.ack0_o, e_ack0);
    chk("ack1", bus.ack1_o, e_ack1);
    chk("rdata0", bus.rdata0_o, (e_ack0 && !g_cmd.we) ? g_rd : '0);
    chk("rdata1", bus.rdata1_o, (e_ack1 && !g_cmd.we) ? g_rd : '0);
    chk("wclk_en", ram_wclk_en, iss && g_cmd.we);
    chk("rclk_en", ram_rclk_en, iss && !g_cmd.we);
    chk("wen", ram_wen, (iss && g_cmd.we) ? g_cmd.be : '0);
    if (iss) begin
      chk("ram_a", ram_a, g_cmd.addr);
      chk("ram_wd", ram_wd, g_cmd.wdata);
    end

    if (bus.ack0_o === 1'b1) note_ack(0);
    if (bus.ack1_o === 1'b1) note_ack(1);
    if (e_ack0 && !g_cmd.we) last_rd[0] = bus.rdata0_o;
    if (e_ack1 && !g_cmd.we) last_rd[1] = bus.rdata1_o;

    for (int p = 0; p < 2; p++) begin
      if (active[p] && ((p == 0) ? e_ack0 : e_ack1)) active[p] = 1'b0;
      if (!active[p] && qsize(p) > 0 && int'($urandom_range(99)) < pct) begin
        cur[p]    = pop(p);
        active[p] = 1'b1;
      end
    end
    drive(iss);

    if (cyc >= free_cyc && (active[0] || active[1])) begin
      if (active[0] && active[1]) w = ~m_last;
      else                        w = active[1];
      m_last   = w;
      g_port   = w;
      g_cmd    = cur[w];
      g_rd     = ref_mem[g_cmd.addr];
      iss_cyc  = cyc + 1;
      done_cyc = cyc + 2;
      free_cyc = cyc + 3;
      if (g_cmd.we)
        for (int b = 0; b < BE_W; b++)
          if (g_cmd.be[b]) ref_mem[g_cmd.addr][8*b +: 8] = g_cmd.wdata[8*b +: 8];
    end
    cyc++;
  endtask

  task automatic run_phase(input int pct);
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) > 0 || active[0] || active[1] || cyc < free_cyc) && n < 3000) begin
      @(negedge clk);
      step(pct);
      n++;
    end
    if (n >= 3000) chk("phase_timeout", n, 0);
    @(negedge clk);
    step(pct);
  endtask

  task automatic clear_obs();
    first_ack_cyc[0] = -1; first_ack_cyc[1] = -1;
    first_port = -1;
    n_ack[0] = 0; n_ack[1] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int start;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cur[0] = '0; cur[1] = '0;
    active[0] = 1'b0; active[1] = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    g_cmd = '0; g_port = 1'b0; g_rd = '0;
    alt_en = 1'b0; prev_ack = -1;
    clear_obs();
    cyc = 0; iss_cyc = -1; done_cyc = -1; free_cyc = 0; m_last = 1'b1;
    drive(1'b0);

    repeat (3) @(negedge clk);
    chk("rst_ack0", bus.ack0_o, 0);
    chk("rst_ack1", bus.ack1_o, 0);
    chk("rst_rdata0", bus.rdata0_o, 0);
    chk("rst_rdata1", bus.rdata1_o, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_wd", ram_wd, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_wclk_en", ram_wclk_en, 0);
    chk("rst_rclk_en", ram_rclk_en, 0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // Simultaneous first requests, write/read, byte lanes.
    clear_obs();
    start = cyc;
    push(0, 1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
    push(0, 1'b0, 9'h005, 32'h0, 4'h0);
    push(1, 1'b1, 9'h1FF, 32'h11223344, 4'hF);
    push(1, 1'b1, 9'h1FF, 32'hAABBCCDD, 4'h5);
    push(1, 1'b0, 9'h1FF, 32'h0, 4'h0);
    run_phase(100);
    chk("tie_ack0_latency", first_ack_cyc[0] - start, 2);
    chk("tie_ack1_latency", first_ack_cyc[1] - start, 5);
    chk("read0_deadbeef", last_rd[0], 32'hDEADBEEF);
    chk("read1_bytelane", last_rd[1], 32'h11BB33DD);

    // Port 0 served alone, then a tie must go to port 1.
    push(0, 1'b0, 9'h005, 32'h0, 4'h0);
    run_phase(100);
    clear_obs();
    push(0, 1'b1, 9'h020, 32'h01234567, 4'hF);
    push(1, 1'b0, 9'h005, 32'h0, 4'h0);
    run_phase(100);
    chk("tie2_first_port", first_port, 1);

    // Write with all byte enables off leaves memory untouched.
    push(0, 1'b1, 9'h010, 32'hCAFEF00D, 4'hF);
    push(0, 1'b1, 9'h010, 32'hFFFFFFFF, 4'h0);
    push(0, 1'b0, 9'h010, 32'h0, 4'h0);
    run_phase(100);
    chk("be0_read", last_rd[0], 32'hCAFEF00D);

    // Continuous contention: 20 accesses, strict alternation.
    clear_obs();
    alt_en = 1'b1; prev_ack = -1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(rand_cmd());
      q1.push_back(rand_cmd());
    end
    run_phase(100);
    alt_en = 1'b0;
    chk("contention_acks0", n_ack[0], 10);
    chk("contention_acks1", n_ack[1], 10);

    // Random traffic with idle gaps.
    for (int i = 0; i < 60; i++) begin
      q0.push_back(rand_cmd());
      q1.push_back(rand_cmd());
    end
    run_phase(40);

    // Reset during ISSUE of a port 1 read.
    @(negedge clk);
    bus.req1_i = 1'b1; bus.we1_i = 1'b0; bus.addr1_i = 9'h1FF;
    bus.wdata1_i = '0; bus.be1_i = '0;
    @(negedge clk);
    chk("rst_issue_rclk", ram_rclk_en, 1);
    chk("rst_issue_addr", ram_a, 9'h1FF);
    rst_n = 1'b0;
    #1;
    chk("async_ack1", bus.ack1_o, 0);
    chk("async_rdata1", bus.rdata1_o, 0);
    chk("async_ram_a", ram_a, 0);
    chk("async_ram_wd", ram_wd, 0);
    chk("async_wen", ram_wen, 0);
    chk("async_wclk_en", ram_wclk_en, 0);
    chk("async_rclk_en", ram_rclk_en, 0);
    repeat (2) begin
      @(negedge clk);
      chk("in_reset_ack1", bus.ack1_o, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_issue_rclk", ram_rclk_en, 1);
    chk("release_issue_addr", ram_a, 9'h1FF);
    chk("release_issue_ack1", bus.ack1_o, 0);
    @(negedge clk);
    chk("release_done_ack1", bus.ack1_o, 1);
    chk("release_done_rdata1", bus.rdata1_o, ref_mem[9'h1FF]);
    chk("release_done_ack0", bus.ack0_o, 0);
    bus.req1_i = 1'b0;
    @(negedge clk);
    chk("release_after_ack1", bus.ack1_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
